// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: turns PS/2 scan codes into character-RAM writes, with hardware row clears and a circular scroll pointer
module text_buffer_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30,
  parameter int ADDR_W = 12,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic clk,
  input  logic clrn,
  input  logic key_valid,
  input  logic [7:0] key_code,
  input  logic [7:0] ascii_in,
  output logic wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(ROWS)-1:0] top_row,
  output logic busy,
  output logic caps,
  output logic overrun,
  output logic [7:0] last_code
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  typedef enum logic [2:0] {INIT, IDLE, BREAK, EXT, CLEAR} state_t;
  state_t state;
  logic shift;
  logic [ADDR_W-1:0] base, cnt, nbase, pbase;
  logic [RW-1:0] nr, pr, nt;
  logic up;
  logic [7:0] ch;
  // base tracks cur_row*COLS incrementally so no multiplier is needed
  always_comb begin
    nr = (cur_row == LAST_ROW) ? '0 : cur_row + RW'(1);
    pr = (cur_row == '0) ? LAST_ROW : cur_row - RW'(1);
    nt = (top_row == LAST_ROW) ? '0 : top_row + RW'(1);
    nbase = (cur_row == LAST_ROW) ? '0 : base + COLS_A;
    pbase = (cur_row == '0) ? LAST_BASE : base - COLS_A;
    up = (shift ^ caps) && ascii_in >= 8'h61 && ascii_in <= 8'h7a;
    ch = up ? ascii_in - 8'h20 : ascii_in;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= INIT;
      cur_col <= '0;
      cur_row <= '0;
      top_row <= '0;
      shift <= 1'b0;
      caps <= 1'b0;
      base <= '0;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= BLANK;
      busy <= 1'b1;
      overrun <= 1'b0;
      last_code <= '0;
    end else begin
      wr_en <= 1'b0;
      overrun <= key_valid && busy;
      case (state)
        INIT: begin
          wr_en <= 1'b1;
          wr_addr <= cnt;
          wr_data <= BLANK;
          cnt <= cnt + ONE_A;
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          wr_en <= 1'b1;
          wr_addr <= base + cnt;
          wr_data <= BLANK;
          cnt <= cnt + ONE_A;
          if (cnt == COLS_A - ONE_A) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        BREAK: if (key_valid) begin
          if (key_code == 8'h12 || key_code == 8'h59) shift <= 1'b0;
          state <= IDLE;
        end
        EXT: if (key_valid) state <= (key_code == 8'hF0) ? BREAK : IDLE;
        default: if (key_valid) begin
          if (key_code != 8'hF0 && key_code != 8'hE0) last_code <= key_code;
          if (key_code == 8'hF0) state <= BREAK;
          else if (key_code == 8'hE0) state <= EXT;
          else if (key_code == 8'h12 || key_code == 8'h59) shift <= 1'b1;
          else if (key_code == 8'h58) caps <= !caps;
          else if (key_code == 8'h66) begin
            if (cur_col != '0) begin
              cur_col <= cur_col - CW'(1);
              wr_en <= 1'b1;
              wr_addr <= base + ADDR_W'(cur_col) - ONE_A;
              wr_data <= BLANK;
            end else if (cur_row != top_row) begin
              cur_row <= pr;
              base <= pbase;
              cur_col <= LAST_COL;
              wr_en <= 1'b1;
              wr_addr <= pbase + COLS_A - ONE_A;
              wr_data <= BLANK;
            end
          end else if (key_code == 8'h5A || ascii_in != '0) begin
            if (key_code != 8'h5A) begin
              wr_en <= 1'b1;
              wr_addr <= base + ADDR_W'(cur_col);
              wr_data <= ch;
            end
            if (key_code == 8'h5A || cur_col == LAST_COL) begin
              cur_col <= '0;
              cur_row <= nr;
              base <= nbase;
              cnt <= '0;
              busy <= 1'b1;
              state <= CLEAR;
              if (nr == top_row) top_row <= nt;
            end else cur_col <= cur_col + CW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: directed scan-code sequences with hand-computed RAM writes and cursor state
module tb_text_buffer_ctrl;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic [7:0] ascii_in = 8'h00;
  logic wr_en, busy, caps, overrun;
  logic [11:0] wr_addr;
  logic [7:0] wr_data, last_code;
  logic [6:0] cur_col;
  logic [4:0] cur_row, top_row;
  int n = 0;
  int errs = 0;

  text_buffer_ctrl dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code), .ascii_in(ascii_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cur_col(cur_col), .cur_row(cur_row),
    .top_row(top_row), .busy(busy), .caps(caps), .overrun(overrun), .last_code(last_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    key_valid = 1'b1;
    key_code = c;
    ascii_in = a;
    tick();
    key_valid = 1'b0;
    ascii_in = 8'h00;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      tick();
      t++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int bad, bc;
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 8'h20);
    chk("rst_col", cur_col, 0);
    chk("rst_row", cur_row, 0);
    chk("rst_top", top_row, 0);
    chk("rst_caps", caps, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_last_code", last_code, 0);
    clrn = 1'b1;
    repeat (50) tick();
    chk("mid_init_addr", wr_addr, 12'd49);
    clrn = 1'b0;
    #1;
    chk("mid_init_rst_wr_en", wr_en, 0);
    chk("mid_init_rst_addr", wr_addr, 0);
    chk("mid_init_rst_busy", busy, 1);
    clrn = 1'b1;
    bad = 0;
    for (int i = 0; i < 2100; i++) begin
      if (i == 100) begin
        key_valid = 1'b1;
        key_code = 8'h1C;
        ascii_in = 8'h61;
      end
      tick();
      if (i == 100) begin
        chk("init_overrun", overrun, 1);
        key_valid = 1'b0;
        ascii_in = 8'h00;
      end
      if (!(wr_en === 1'b1 && wr_addr === 12'(i) && wr_data === 8'h20 && busy === (i < 2099))) bad++;
    end
    chk("init_writes", bad, 0);
    tick();
    chk("init_done_wr_en", wr_en, 0);
    chk("init_done_busy", busy, 0);
    chk("init_done_overrun", overrun, 0);
    chk("init_key_dropped_col", cur_col, 0);

    send(8'h1C, 8'h61);
    chk("a_wr_en", wr_en, 1);
    chk("a_addr", wr_addr, 0);
    chk("a_data", wr_data, 8'h61);
    chk("a_col", cur_col, 1);
    chk("a_last_code", last_code, 8'h1C);
    send(8'hF0, 8'h00);
    chk("f0_no_write", wr_en, 0);
    send(8'h1C, 8'h61);
    chk("break_no_write", wr_en, 0);
    chk("break_col", cur_col, 1);

    send(8'h12, 8'h00);
    chk("shift_no_write", wr_en, 0);
    send(8'h1C, 8'h61);
    chk("shift_a_data", wr_data, 8'h41);
    chk("shift_a_addr", wr_addr, 1);
    send(8'hF0, 8'h00);
    send(8'h12, 8'h00);
    chk("shift_rel_no_write", wr_en, 0);
    send(8'h1C, 8'h61);
    chk("unshift_a_data", wr_data, 8'h61);
    chk("unshift_a_addr", wr_addr, 2);
    send(8'h58, 8'h00);
    chk("caps_on", caps, 1);
    send(8'h1C, 8'h61);
    chk("caps_a_data", wr_data, 8'h41);
    chk("caps_a_addr", wr_addr, 3);
    send(8'h12, 8'h00);
    send(8'h1C, 8'h61);
    chk("caps_shift_a_data", wr_data, 8'h61);
    chk("caps_shift_a_addr", wr_addr, 4);
    send(8'hF0, 8'h00);
    send(8'h12, 8'h00);
    send(8'h16, 8'h31);
    chk("caps_digit_data", wr_data, 8'h31);
    chk("caps_digit_addr", wr_addr, 5);
    send(8'h58, 8'h00);
    chk("caps_off", caps, 0);
    chk("caps_last_code", last_code, 8'h58);
    send(8'hE0, 8'h00);
    send(8'h75, 8'h38);
    chk("ext_no_write", wr_en, 0);
    chk("ext_last_code", last_code, 8'h58);
    send(8'hE0, 8'h00);
    send(8'hF0, 8'h00);
    send(8'h75, 8'h00);
    chk("ext_break_no_write", wr_en, 0);
    send(8'h1C, 8'h61);
    chk("post_ext_data", wr_data, 8'h61);
    chk("post_ext_addr", wr_addr, 6);
    chk("post_ext_col", cur_col, 7);
    send(8'h66, 8'h08);
    chk("bs_wr_en", wr_en, 1);
    chk("bs_addr", wr_addr, 6);
    chk("bs_data", wr_data, 8'h20);
    chk("bs_col", cur_col, 6);

    bad = 0;
    for (int k = 0; k < 64; k++) begin
      send(8'h32, 8'h62);
      if (!(wr_en === 1'b1 && wr_addr === 12'(6 + k) && wr_data === 8'h62)) bad++;
    end
    chk("row0_fill", bad, 0);
    chk("wrap_col", cur_col, 0);
    chk("wrap_row", cur_row, 1);
    bc = int'(busy);
    bad = 0;
    for (int j = 0; j < 70; j++) begin
      if (j == 10 || j == 69) begin
        key_valid = 1'b1;
        key_code = 8'h1C;
        ascii_in = 8'h61;
      end
      tick();
      key_valid = 1'b0;
      ascii_in = 8'h00;
      if (j == 10 || j == 69) chk("clear_overrun", overrun, 1);
      if (!(wr_en === 1'b1 && wr_addr === 12'(70 + j) && wr_data === 8'h20)) bad++;
      bc += int'(busy);
    end
    chk("clear_writes", bad, 0);
    chk("clear_busy_cycles", bc, 70);
    tick();
    chk("clear_done_wr_en", wr_en, 0);
    chk("clear_done_overrun", overrun, 0);
    chk("clear_done_col", cur_col, 0);
    chk("clear_done_row", cur_row, 1);

    send(8'h66, 8'h08);
    chk("bs_up_wr_en", wr_en, 1);
    chk("bs_up_addr", wr_addr, 69);
    chk("bs_up_data", wr_data, 8'h20);
    chk("bs_up_col", cur_col, 69);
    chk("bs_up_row", cur_row, 0);
    bad = 0;
    for (int k = 0; k < 69; k++) begin
      send(8'h66, 8'h08);
      if (!(wr_en === 1'b1 && wr_addr === 12'(68 - k))) bad++;
    end
    chk("bs_run", bad, 0);
    send(8'h66, 8'h08);
    chk("bs_home_no_write", wr_en, 0);
    chk("bs_home_col", cur_col, 0);
    chk("bs_home_row", cur_row, 0);
    chk("bs_last_code", last_code, 8'h66);

    bad = 0;
    for (int i = 0; i < 29; i++) begin
      send(8'h5A, 8'h00);
      if (!(wr_en === 1'b0 && cur_row === 5'(i + 1) && cur_col === 7'd0 && busy === 1'b1)) bad++;
      wait_idle();
    end
    chk("enter_run", bad, 0);
    chk("enter_row29", cur_row, 29);
    chk("enter_top0", top_row, 0);
    send(8'h5A, 8'h00);
    chk("scroll_row", cur_row, 0);
    chk("scroll_top", top_row, 1);
    bad = 0;
    for (int j = 0; j < 70; j++) begin
      tick();
      if (!(wr_en === 1'b1 && wr_addr === 12'(j) && wr_data === 8'h20)) bad++;
    end
    chk("scroll_clear", bad, 0);
    tick();
    chk("scroll_idle", busy, 0);
    send(8'h66, 8'h08);
    chk("bs_wrap_addr", wr_addr, 2099);
    chk("bs_wrap_wr_en", wr_en, 1);
    chk("bs_wrap_col", cur_col, 69);
    chk("bs_wrap_row", cur_row, 29);
    chk("bs_wrap_top", top_row, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
